// File: rtl/md4_block_padder_if.sv
// Byte-stream input and 512-bit block output of the MD4 message padder.
interface md4_block_padder_if;
  logic         in_valid;
  logic [7:0]   in_byte;
  logic         in_last;
  logic         in_ready;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         blk_ready;

  // Byte producer / block consumer side.
  modport master (
    output in_valid, in_byte, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );

  // Padder side.
  modport slave (
    input  in_valid, in_byte, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/md4_block_padder.sv
// Buffers a byte stream into 512-bit MD4 message blocks and appends MD4
// padding (0x80, zero fill, 64-bit little-endian bit length) after the last
// byte. Byte j of a block sits at blk_data[8j+7:8j].
module md4_block_padder #(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  md4_block_padder_if.slave  bus
);

  localparam int unsigned BLK_BYTES = 64;
  localparam int unsigned BLK_W     = 8 * BLK_BYTES;
  localparam int unsigned PTR_W     = 7;
  localparam int unsigned LEN_W     = 64;
  localparam int unsigned LEN_POS   = 56;
  localparam int unsigned LEN_BYTES = LEN_W / 8;

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_PAD   = 2'd1,
    S_LEN   = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  state_t             nae_q;
  logic               final_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_inc;
  logic [CNT_W-1:0]   cnt_q;
  logic [BLK_W-1:0]   buf_q, buf_d;
  logic               blk_valid_q, blk_last_q;
  logic [LEN_W-1:0]   bit_len;

  logic               in_ready_c;
  logic               byte_xfer;
  logic               blk_xfer;
  logic               ptr_full;

  // Datapath controls decoded from the FSM.
  logic               wr_byte;
  logic               do_pad;
  logic               do_len;
  logic               do_clear;
  logic               clr_cnt;
  logic               final_ld;
  logic               final_val;
  logic               final_next;
  logic               nae_ld;
  state_t             nae_val;

  assign in_ready_c = (state_q == S_ACCUM) && !rst;
  assign byte_xfer  = bus.in_valid && in_ready_c;
  assign blk_xfer   = (state_q == S_EMIT) && bus.blk_ready;
  assign ptr_inc    = ptr_q + PTR_W'(1);
  assign ptr_full   = (ptr_inc == PTR_W'(BLK_BYTES));
  assign bit_len    = LEN_W'({cnt_q, 3'b000});
  assign final_next = final_ld ? final_val : final_q;

  assign bus.in_ready  = in_ready_c;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_last  = blk_last_q;
  assign bus.blk_data  = buf_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACCUM: begin
        if (byte_xfer) begin
          if (bus.in_last) begin
            state_d = ptr_full ? S_EMIT : S_PAD;
          end else if (ptr_full) begin
            state_d = S_EMIT;
          end
        end
      end
      S_PAD:  state_d = S_EMIT;
      S_LEN:  state_d = S_EMIT;
      S_EMIT: begin
        if (bus.blk_ready) begin
          state_d = final_q ? S_ACCUM : nae_q;
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  // Datapath control decode per state.
  always_comb begin
    wr_byte   = 1'b0;
    do_pad    = 1'b0;
    do_len    = 1'b0;
    do_clear  = 1'b0;
    clr_cnt   = 1'b0;
    final_ld  = 1'b0;
    final_val = 1'b0;
    nae_ld    = 1'b0;
    nae_val   = S_ACCUM;
    unique case (state_q)
      S_ACCUM: begin
        if (byte_xfer) begin
          wr_byte = 1'b1;
          if (ptr_full) begin
            final_ld  = 1'b1;
            final_val = 1'b0;
            nae_ld    = 1'b1;
            nae_val   = bus.in_last ? S_PAD : S_ACCUM;
          end
        end
      end
      S_PAD: begin
        do_pad   = 1'b1;
        final_ld = 1'b1;
        if (ptr_q <= PTR_W'(LEN_POS - 1)) begin
          final_val = 1'b1;
        end else begin
          final_val = 1'b0;
          nae_ld    = 1'b1;
          nae_val   = S_LEN;
        end
      end
      S_LEN: begin
        do_len    = 1'b1;
        final_ld  = 1'b1;
        final_val = 1'b1;
      end
      S_EMIT: begin
        if (blk_xfer) begin
          do_clear = 1'b1;
          clr_cnt  = final_q;
        end
      end
      default: ;
    endcase
  end

  // Next buffer contents: byte write, padding, length-only block or clear.
  always_comb begin
    buf_d = buf_q;
    if (do_clear) begin
      buf_d = '0;
    end else if (wr_byte) begin
      for (int j = 0; j < int'(BLK_BYTES); j++) begin
        if (ptr_q == PTR_W'(j)) begin
          buf_d[8*j +: 8] = bus.in_byte;
        end
      end
    end else if (do_pad) begin
      for (int j = 0; j < int'(BLK_BYTES); j++) begin
        if (ptr_q == PTR_W'(j)) begin
          buf_d[8*j +: 8] = 8'h80;
        end else if (ptr_q < PTR_W'(j)) begin
          buf_d[8*j +: 8] = 8'h00;
        end
      end
      if (ptr_q <= PTR_W'(LEN_POS - 1)) begin
        for (int k = 0; k < int'(LEN_BYTES); k++) begin
          buf_d[8*(int'(LEN_POS) + k) +: 8] = bit_len[8*k +: 8];
        end
      end
    end else if (do_len) begin
      buf_d = '0;
      for (int k = 0; k < int'(LEN_BYTES); k++) begin
        buf_d[8*(int'(LEN_POS) + k) +: 8] = bit_len[8*k +: 8];
      end
    end
  end

  // Buffer, pointer, byte counter, emit bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      final_q     <= 1'b0;
      nae_q       <= S_ACCUM;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      buf_q <= buf_d;
      if (do_clear) begin
        ptr_q <= '0;
      end else if (wr_byte) begin
        ptr_q <= ptr_inc;
      end
      if (do_clear && clr_cnt) begin
        cnt_q <= '0;
      end else if (wr_byte) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (final_ld) begin
        final_q <= final_val;
      end
      if (nae_ld) begin
        nae_q <= nae_val;
      end
      blk_valid_q <= (state_d == S_EMIT);
      blk_last_q  <= (state_d == S_EMIT) && final_next;
    end
  end

endmodule

// File: tb/tb_md4_block_padder.sv
// Self-checking bench for md4_block_padder: directed cases plus random
// messages scored against a queue-based MD4 padding model.
module tb_md4_block_padder;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [511:0] data;
    logic         last;
  } blk_t;

  logic clk;
  logic rst;
  md4_block_padder_if bus ();

  md4_block_padder #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  blk_t exp_q[$];
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit   bp_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: standard MD4 padding of the whole message, split into blocks.
  function automatic void model_push(input byte_q_t msg);
    byte_q_t     p;
    logic [63:0] bl;
    blk_t        e;
    int          nb;
    p  = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 0; k < 8; k++) p.push_back(bl[8*k +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int j = 0; j < 64; j++) e.data[8*j +: 8] = p[b*64 + j];
      e.last = (b == nb - 1);
      exp_q.push_back(e);
    end
  endfunction

  // blk_ready driver.
  initial begin
    bus.blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.blk_ready = 1'b1;
        1:       bus.blk_ready = 1'($urandom_range(0, 1));
        default: bus.blk_ready = 1'b0;
      endcase
    end
  end

  // Block monitor: every transferred block is compared with the model.
  initial begin
    blk_t e;
    forever begin
      @(negedge clk);
      if (bus.blk_valid && bus.blk_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_blk", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("blk_data", bus.blk_data, e.data);
          check("blk_last", bus.blk_last, e.last);
        end
      end
    end
  end

  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap_pct);
    int  n;
    logic rdy;
    while (int'($urandom_range(0, 99)) < gap_pct) idle();
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_last  = last;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 500) begin
      @(negedge clk);
      rdy = bus.in_ready;
      if (!rdy) begin
        @(posedge clk);
        n++;
      end
    end
    if (!rdy) check("in_ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input byte_q_t msg, input int gap_pct);
    model_push(msg);
    for (int i = 0; i < msg.size(); i++) send_byte(msg[i], i == msg.size() - 1, gap_pct);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check(tag, exp_q.size() == 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    byte_q_t msg;
    logic [511:0] snap;
    int n;
    int blens[10] = '{1, 55, 56, 57, 63, 64, 65, 119, 120, 128};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_last  = 1'b0;
    #2;
    check("rst_blk_valid", bus.blk_valid, 1'b0);
    check("rst_blk_last", bus.blk_last, 1'b0);
    check("rst_blk_data", bus.blk_data, '0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", bus.in_ready, 1'b1);

    // Reset in the middle of a block discards the partial data.
    for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i), 1'b0, 0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_blk_valid", bus.blk_valid, 1'b0);
    check("midrst_blk_data", bus.blk_data, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // "abc" with latency and explicit word checks.
    ready_mode = 0;
    msg = '{8'h61, 8'h62, 8'h63};
    model_push(msg);
    send_byte(8'h61, 1'b0, 0);
    send_byte(8'h62, 1'b0, 0);
    send_byte(8'h63, 1'b1, 0);
    check("abc_valid_t", bus.blk_valid, 1'b0);
    check("abc_ready_pad", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("abc_valid_t1", bus.blk_valid, 1'b1);
    check("abc_last", bus.blk_last, 1'b1);
    check("abc_word0", bus.blk_data[31:0], 32'h80636261);
    check("abc_word14", bus.blk_data[479:448], 32'h00000018);
    check("abc_words1_13", bus.blk_data[447:32], '0);
    check("abc_word15", bus.blk_data[511:480], '0);
    drain("abc_drain");

    // 56 bytes of 0x41: padding spills into a length-only block.
    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(8'h41);
    send_msg(msg, 0);
    drain("m56_drain");

    // 64 bytes 0x00..0x3F: raw block immediately after the 64th byte.
    msg = {};
    for (int i = 0; i < 64; i++) msg.push_back(8'(i));
    model_push(msg);
    for (int i = 0; i < 64; i++) send_byte(msg[i], i == 63, 0);
    check("m64_valid_t", bus.blk_valid, 1'b1);
    check("m64_last0", bus.blk_last, 1'b0);
    check("m64_word0", bus.blk_data[31:0], 32'h03020100);
    drain("m64_drain");

    // Backpressure on a full non-final block.
    ready_mode = 2;
    bp_done    = 1'b0;
    msg = {};
    for (int i = 0; i < 70; i++) msg.push_back(8'(i));
    fork
      begin
        send_msg(msg, 0);
        bp_done = 1'b1;
      end
    join_none
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.blk_valid && n < 200);
    check("bp_valid_seen", bus.blk_valid, 1'b1);
    snap = bus.blk_data;
    check("bp_word0", snap[31:0], 32'h03020100);
    check("bp_last0", bus.blk_last, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_hold_data", bus.blk_data, snap);
      check("bp_hold_ready", bus.in_ready, 1'b0);
      check("bp_hold_valid", bus.blk_valid, 1'b1);
    end
    ready_mode = 0;
    n = 0;
    while (!bp_done && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("bp_send_done", bp_done, 1'b1);
    drain("bp_drain");

    // Boundary lengths and random messages with random gaps.
    ready_mode = 1;
    for (int m = 0; m < 10; m++) begin
      msg = {};
      for (int i = 0; i < blens[m]; i++) msg.push_back(8'($urandom));
      send_msg(msg, 25);
      drain("bound_drain");
    end
    for (int m = 0; m < 15; m++) begin
      msg = {};
      n = int'($urandom_range(1, 200));
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      send_msg(msg, 30);
      drain("rand_drain");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md4_block_padder.md
# md4_block_padder

Message-side producer for the MD4 round pipeline. It accepts a byte stream and buffers it into 512-bit message blocks, which it presents on a valid/ready port. On the last byte it appends MD4 padding: byte 0x80, then zero fill, then the 64-bit little-endian message bit length. Its 512-bit output uses exactly the word layout the round stages consume: word i = blk_data[32i+31:32i], and byte j of the block = blk_data[8j+7:8j].

## Interface
- CNT_W, 32: width of the message byte counter. Bit length = {count, 3'b000}, zero-extended to 64 bits. The counter wraps modulo 2^CNT_W.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_byte is valid this cycle.
- in_byte  input  8  message byte.
- in_last  input  1  qualifies in_byte as the final message byte. Ignored unless in_valid is high.
- in_ready  output  1  padder accepts a byte this cycle. Equals (state==ACCUM) && !rst.
- blk_valid  output  1  blk_data holds a complete block.
- blk_data  output  512  block; byte j at [8j+7:8j].
- blk_last  output  1  this block is the final (length-carrying) block of the message.
- blk_ready  input  1  consumer takes the block this cycle.

## Operation
- Byte transfer: in_valid && in_ready. Block transfer: blk_valid && blk_ready.
- Internal state:
  - 64-byte buffer.
  - ptr: 7 bits, 0..64, position in the current block.
  - cnt: CNT_W bits, total message bytes.
  - next_after_emit: which state follows EMIT.
  - final flag.
- States:
  - ACCUM: each transferred byte is written to buf[ptr]; ptr++ and cnt++.
    - Transfer with in_last: go to PAD if the new ptr ≤ 63. If the new ptr = 64, go to EMIT with final=0 and next_after_emit=PAD.
    - Transfer without in_last that makes ptr = 64: go to EMIT with final=0 and next_after_emit=ACCUM.
  - PAD (one cycle): buf[ptr] ← 0x80 and buf[ptr+1..63] ← 0.
    - If ptr ≤ 55: buf[56..63] ← 64-bit little-endian bit length; go to EMIT with final=1.
    - If ptr is 56..63: go to EMIT with final=0 and next_after_emit=LEN.
  - LEN (one cycle): buf[0..55] ← 0 and buf[56..63] ← bit length; go to EMIT with final=1.
  - EMIT: blk_valid=1 and blk_last=final. blk_data is held stable until transfer. On transfer: ptr ← 0, buffer cleared, go to next_after_emit. If final, also cnt ← 0 and go to ACCUM.
- Entering PAD from EMIT (the message ended exactly on a 64-byte boundary) runs with ptr=0. This produces an all-padding final block: byte 0 = 0x80 and the length in bytes 56..63.
- Zero-length messages are not supported; in_last always accompanies a real byte.
- in_byte and in_last are ignored whenever in_ready is low.

## Timing
- Reset (asynchronous, immediate) values:
  - state=ACCUM; ptr=0; cnt=0; buffer all zero.
  - blk_valid=0, blk_last=0, blk_data=0, in_ready=0.
  - in_ready rises in the first cycle after rst deasserts.
- Reset mid-operation discards the partial block and any pending EMIT. blk_valid falls asynchronously with rst.
- Non-final full block: 64th byte accepted at edge t → blk_valid high after edge t. in_ready is low from then until the block transfers.
- Final block, ptr ≤ 55 after last byte: last byte accepted at edge t → PAD during t..t+1 → blk_valid=1 with blk_last=1 after edge t+1.
- ptr 56..63: two blocks. The first (blk_last=0) is valid after edge t+1. After its transfer at edge u: LEN, then the second block (blk_last=1) is valid after edge u+1.
- blk_ready held high continuously sustains one block per emit cycle. There is no bubble other than the PAD/LEN cycles.
- in_ready is 0 in PAD, LEN and EMIT.
- The new message's first byte may be accepted in the cycle after the final block transfers.

## Test plan
- Reset: assert rst mid-block with 10 bytes buffered, then release, then send "abc" → exactly one block, with no remnants of the earlier bytes.
- "abc" (61,62,63 with last), blk_ready=1:
  - blk_valid 2 cycles after the last byte.
  - blk_data[31:0]=32'h80636261; words 1..13 = 0; word 14 = 32'h00000018; word 15 = 0; blk_last=1.
- 56-byte message of 0x41 with last:
  - block 1: bytes 0..55 = 0x41, byte 56 = 0x80, rest 0, blk_last=0.
  - block 2: word 14 = 32'h000001C0, all other bits 0, blk_last=1.
- 64-byte message (0x00..0x3F):
  - block 1 = raw data with word 0 = 32'h03020100, blk_last=0.
  - block 2: word 0 = 32'h00000080, word 14 = 32'h00000200, blk_last=1.
- Backpressure: hold blk_ready=0 for 20 cycles during EMIT of a full block → blk_data stable, in_ready=0, no bytes lost. After release, the next bytes land at ptr=0.
- Random streams of 1..200 bytes with random in_valid/blk_ready gaps → block count and padding checked against a reference model; cnt restarts per message.
